// File: rtl/adc_os_pkg.sv
// Shared types and sizing helpers for the multi-channel ADC oversampler.
// Optional feature macro: ADC_OS_ROUND_EN (round-half-up result instead of truncation).
package adc_os_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_ACQ    = 2'd2,
    ST_EMIT   = 2'd3
  } state_t;

  // Bits needed to index n items, never less than one so a 1-channel build still has a select.
  function automatic int clog2_min1(input int n);
    int r;
    r = $clog2(n);
    return (r < 1) ? 1 : r;
  endfunction

  // Accumulator width that holds (2^dw - 1) * 2^osr_log2 without wrapping.
  function automatic int acc_width(input int dw, input int osr_log2);
    return dw + osr_log2;
  endfunction

endpackage

// File: rtl/adc_os_if.sv
// Sample-source, control and result bus of the ADC oversampler.
// Handshake: a result transfers on any cycle where result_valid && result_ready; while
// result_valid is high, result_data and result_ch stay stable until that cycle.
// Optional feature macro: ADC_OS_ROUND_EN (affects the result value only, not this bus).
interface adc_os_if #(
  parameter int DATA_W = 8,
  parameter int CH_W   = 2
);
  logic              start;
  logic              cont;
  logic [CH_W-1:0]   ch_sel;
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic [DATA_W-1:0] result_data;
  logic [CH_W-1:0]   result_ch;
  logic              result_valid;
  logic              result_ready;
  logic              busy;
  logic              done;

  // Oversampler side.
  modport master (
    input  start, cont, sample_in, sample_valid, result_ready,
    output ch_sel, result_data, result_ch, result_valid, busy, done
  );

  // Sample source / consumer side.
  modport slave (
    output start, cont, sample_in, sample_valid, result_ready,
    input  ch_sel, result_data, result_ch, result_valid, busy, done
  );
endinterface

// File: rtl/adc_os_accum.sv
// Per-channel accumulator: sums 2^OSR_LOG2 samples and forms the mean.
// Optional feature macro: ADC_OS_ROUND_EN selects round-half-up instead of truncation.
module adc_os_accum
  import adc_os_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int OSR_LOG2 = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              add_en,
  input  logic [DATA_W-1:0] sample_in,
  output logic              last,
  output logic [DATA_W-1:0] result
);
  localparam int ACC_W = acc_width(DATA_W, OSR_LOG2);

  logic [ACC_W-1:0]    acc_q;
  logic [OSR_LOG2-1:0] cnt_q;
  logic [ACC_W-1:0]    sum;

  // The result is formed from acc plus the incoming sample so it can be registered on the last sample.
  assign sum  = acc_q + ACC_W'(sample_in);
  assign last = &cnt_q;

`ifdef ADC_OS_ROUND_EN
  localparam logic [ACC_W-1:0] HALF = ACC_W'(1) << (OSR_LOG2 - 1);
  logic [ACC_W-1:0] rounded;
  // The rounded sum cannot exceed 2^ACC_W-1, so no saturation is needed.
  assign rounded = sum + HALF;
  assign result  = DATA_W'(rounded >> OSR_LOG2);
`else
  assign result  = DATA_W'(sum >> OSR_LOG2);
`endif

  // Accumulate accepted samples; clear at the start of every channel.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (add_en) begin
      acc_q <= sum;
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/adc_oversampler.sv
// Multi-channel oversampling ADC front-end: scans NUM_CH mux inputs, discards SETTLE samples
// after each switch, averages 2^OSR_LOG2 samples and emits one mean per channel.
// Optional feature macro: ADC_OS_ROUND_EN (round-half-up mean).
module adc_oversampler
  import adc_os_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int NUM_CH   = 4,
  parameter int OSR_LOG2 = 4,
  parameter int SETTLE   = 2
) (
  input  logic          clk,
  input  logic          rst,
  adc_os_if.master      bus,
  output state_t        dbg_state
);
  localparam int CH_W        = clog2_min1(NUM_CH);
  localparam int SC_W        = clog2_min1(SETTLE + 1);
  localparam int SETTLE_LAST = (SETTLE > 0) ? SETTLE - 1 : 0;
  localparam state_t ST_FIRST = (SETTLE == 0) ? ST_ACQ : ST_SETTLE;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [SC_W-1:0]   settle_q, settle_d;
  logic              cont_q, cont_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] result_data_q;
  logic [CH_W-1:0]   result_ch_q;
  logic              acc_clear, add_en, res_load, acc_last;
  logic [DATA_W-1:0] acc_result;

  adc_os_accum #(.DATA_W(DATA_W), .OSR_LOG2(OSR_LOG2)) u_accum (
    .clk       (clk),
    .rst       (rst),
    .clear     (acc_clear),
    .add_en    (add_en),
    .sample_in (bus.sample_in),
    .last      (acc_last),
    .result    (acc_result)
  );

  // Next-state, channel/settle counters and accumulator control.
  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    settle_d  = settle_q;
    cont_d    = cont_q;
    done_d    = 1'b0;
    acc_clear = 1'b0;
    add_en    = 1'b0;
    res_load  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          cont_d    = bus.cont;
          ch_d      = '0;
          settle_d  = '0;
          acc_clear = 1'b1;
          state_d   = ST_FIRST;
        end
      end
      ST_SETTLE: begin
        if (bus.sample_valid) begin
          if (settle_q == SC_W'(SETTLE_LAST)) begin
            settle_d = '0;
            state_d  = ST_ACQ;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
      end
      ST_ACQ: begin
        add_en = bus.sample_valid;
        if (bus.sample_valid && acc_last) begin
          res_load = 1'b1;
          state_d  = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (bus.result_ready) begin
          acc_clear = 1'b1;
          settle_d  = '0;
          if (ch_q != CH_W'(NUM_CH - 1)) begin
            ch_d    = ch_q + 1'b1;
            state_d = ST_FIRST;
          end else if (cont_q) begin
            ch_d    = '0;
            state_d = ST_FIRST;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ch_q          <= '0;
      settle_q      <= '0;
      cont_q        <= 1'b0;
      done_q        <= 1'b0;
      result_data_q <= '0;
      result_ch_q   <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      settle_q <= settle_d;
      cont_q   <= cont_d;
      done_q   <= done_d;
      if (res_load) begin
        result_data_q <= acc_result;
        result_ch_q   <= ch_q;
      end
    end
  end

  assign bus.ch_sel       = ch_q;
  assign bus.result_data  = result_data_q;
  assign bus.result_ch    = result_ch_q;
  assign bus.result_valid = (state_q == ST_EMIT);
  assign bus.busy         = (state_q != ST_IDLE);
  assign bus.done         = done_q;
  assign dbg_state        = state_q;
endmodule

// File: tb/tb_adc_oversampler.sv
// Directed bench for adc_oversampler: DATA_W=8, NUM_CH=2, OSR_LOG2=2, SETTLE=1.
// Optional feature macro: ADC_OS_ROUND_EN (changes some expected means).
module tb_adc_oversampler;
  import adc_os_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t dbg_state;
  int     n_cmp  = 0;
  int     n_fail = 0;

`ifdef ADC_OS_ROUND_EN
  localparam int EXP_SCAN_CH0 = 12;
  localparam int EXP_CONT_CH0 = 3;
`else
  localparam int EXP_SCAN_CH0 = 11;
  localparam int EXP_CONT_CH0 = 2;
`endif

  adc_os_if #(.DATA_W(8), .CH_W(1)) bus ();

  adc_oversampler #(.DATA_W(8), .NUM_CH(2), .OSR_LOG2(2), .SETTLE(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] v);
    bus.sample_valid = 1'b1;
    bus.sample_in    = v;
    tick();
    bus.sample_valid = 1'b0;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ch_sel"},  int'(bus.ch_sel), 0);
    chk({tag, "_rdata"},   int'(bus.result_data), 0);
    chk({tag, "_rch"},     int'(bus.result_ch), 0);
    chk({tag, "_rvalid"},  int'(bus.result_valid), 0);
    chk({tag, "_busy"},    int'(bus.busy), 0);
    chk({tag, "_done"},    int'(bus.done), 0);
    chk({tag, "_state"},   int'(dbg_state), int'(ST_IDLE));
  endtask

  initial begin
    bus.start = 1'b0; bus.cont = 1'b0; bus.sample_in = '0;
    bus.sample_valid = 1'b0; bus.result_ready = 1'b1;

    // reset
    tick(); tick();
    chk_reset_vals("rst");
    // rst together with start stays idle
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    rst = 1'b0;
    chk("rst_start_state", int'(dbg_state), int'(ST_IDLE));
    chk("rst_start_busy", int'(bus.busy), 0);

    // single scan, cont=0
    bus.start = 1'b1; bus.cont = 1'b0;
    tick();
    bus.start = 1'b0;
    chk("scan_busy", int'(bus.busy), 1);
    chk("scan_state_settle", int'(dbg_state), int'(ST_SETTLE));
    send(8'd99);
    chk("scan_state_acq", int'(dbg_state), int'(ST_ACQ));
    send(8'd10); send(8'd11); send(8'd12);
    chk("scan_no_valid_early", int'(bus.result_valid), 0);
    send(8'd13);
    chk("scan0_valid", int'(bus.result_valid), 1);
    chk("scan0_data", int'(bus.result_data), EXP_SCAN_CH0);
    chk("scan0_ch", int'(bus.result_ch), 0);
    tick();
    chk("scan_ch_sel1", int'(bus.ch_sel), 1);
    chk("scan_valid_drop", int'(bus.result_valid), 0);
    send(8'd0); send(8'd4); send(8'd4); send(8'd4); send(8'd4);
    chk("scan1_data", int'(bus.result_data), 4);
    chk("scan1_ch", int'(bus.result_ch), 1);
    chk("scan1_done_before", int'(bus.done), 0);
    tick();
    chk("scan_done", int'(bus.done), 1);
    chk("scan_busy_low", int'(bus.busy), 0);
    tick();
    chk("scan_done_once", int'(bus.done), 0);

    // full-scale
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) send(8'd255);
    chk("fs0_data", int'(bus.result_data), 255);
    chk("fs0_acc", int'(dut.u_accum.acc_q), 1020);
    tick();
    for (int i = 0; i < 5; i++) send(8'd255);
    chk("fs1_data", int'(bus.result_data), 255);
    chk("fs1_ch", int'(bus.result_ch), 1);
    tick();
    chk("fs_done", int'(bus.done), 1);

    // backpressure
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    send(8'd7); send(8'd20); send(8'd30); send(8'd40);
    bus.result_ready = 1'b0;
    send(8'd50);
    for (int i = 0; i < 5; i++) begin
      bus.sample_valid = (i % 2 == 0);
      bus.sample_in    = 8'd200;
      tick();
      chk("bp_valid", int'(bus.result_valid), 1);
      chk("bp_data", int'(bus.result_data), 35);
      chk("bp_ch_sel", int'(bus.ch_sel), 0);
    end
    bus.sample_valid = 1'b0;
    bus.result_ready = 1'b1;
    tick();
    chk("bp_ch_sel_after", int'(bus.ch_sel), 1);
    send(8'd1); send(8'd8); send(8'd8); send(8'd8); send(8'd9);
    chk("bp1_data", int'(bus.result_data), 8);
    tick();
    chk("bp_done", int'(bus.done), 1);

    // continuous wrap
    bus.start = 1'b1; bus.cont = 1'b1;
    tick();
    bus.start = 1'b0;
    send(8'd0); send(8'd1); send(8'd2);
    bus.start = 1'b1; bus.cont = 1'b0;
    tick();
    bus.start = 1'b0;
    chk("cont_start_ignored", int'(dbg_state), int'(ST_ACQ));
    send(8'd3); send(8'd4);
    chk("cont0_data", int'(bus.result_data), EXP_CONT_CH0);
    tick();
    send(8'd0);
    for (int i = 0; i < 4; i++) send(8'd100);
    chk("cont1_data", int'(bus.result_data), 100);
    tick();
    chk("cont_wrap_ch_sel", int'(bus.ch_sel), 0);
    chk("cont_wrap_no_done", int'(bus.done), 0);
    chk("cont_wrap_busy", int'(bus.busy), 1);
    chk("cont_wrap_state", int'(dbg_state), int'(ST_SETTLE));
    send(8'd0);
    for (int i = 0; i < 4; i++) send(8'd5);
    chk("cont0b_data", int'(bus.result_data), 5);
    tick();
    send(8'd0); send(8'd77); send(8'd77);

    // reset mid-ACQ
    rst = 1'b1;
    tick();
    chk_reset_vals("midrst");
    rst = 1'b0;
    bus.start = 1'b1; bus.cont = 1'b0;
    tick();
    bus.start = 1'b0;
    send(8'd9);
    for (int i = 0; i < 4; i++) send(8'd40);
    chk("fresh_data", int'(bus.result_data), 40);
    chk("fresh_ch", int'(bus.result_ch), 0);
    tick();
    for (int i = 0; i < 5; i++) send(8'd0);
    chk("fresh1_data", int'(bus.result_data), 0);
    tick();
    chk("fresh_done", int'(bus.done), 1);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_oversampler.md
# adc_oversampler

Parametrised multi-channel oversampling ADC front-end, replacing the single-channel fixed-count accumulator.
- Scans NUM_CH channels through an external analog mux, discards settling samples after each switch, and averages 2^OSR_LOG2 samples per channel into a full-width accumulator that cannot overflow.
- Delivers one mean per channel over a valid/ready handshake.
- Sits between the ADC sample source and the register/bus side of the design.

## Interface
- DATA_W, 8: sample and result width.
- NUM_CH, 4: channels per scan (≥1).
- OSR_LOG2, 4: log2 of samples averaged per channel (≥1).
- SETTLE, 2: samples discarded after each ch_sel change (≥0).
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins a scan when idle; ignored while busy.
- cont  in  1  continuous mode; sampled only on an accepted start.
- ch_sel  out  CH_W  mux select (CH_W = max(1, clog2(NUM_CH))).
- sample_in  in  DATA_W  unsigned ADC sample.
- sample_valid  in  1  sample_in is valid this cycle.
- result_data  out  DATA_W  channel mean.
- result_ch  out  CH_W  channel of result_data.
- result_valid  out  1  result available.
- result_ready  in  1  consumer accepts result.
- busy  out  1  high in any state but IDLE.
- done  out  1  one-cycle pulse when a single scan completes.

## Operation
- States: IDLE, SETTLE, ACQ, EMIT.
- IDLE:
  - start=1 → latch cont, ch=0, clear acc/counters.
  - Next state is SETTLE, or ACQ if SETTLE=0.
- SETTLE: each sample_valid increments the discard count. After SETTLE discards → ACQ. Discarded samples never reach acc.
- ACQ:
  - Each sample_valid: acc += sample_in, cnt++.
  - The 2^OSR_LOG2-th sample registers the result → EMIT.
- acc width is DATA_W+OSR_LOG2; the worst-case sum (2^DATA_W−1)·2^OSR_LOG2 fits, so there is no wrap.
- Result = acc >> OSR_LOG2 (truncate), or rounded per Configuration.
- EMIT:
  - result_valid=1; result_data and result_ch held stable until result_ready.
  - On handshake with ch<NUM_CH−1: ch++, clear acc/counters → SETTLE.
  - On handshake with ch=NUM_CH−1 and cont=1: ch=0 → SETTLE; done is not pulsed.
  - On handshake with ch=NUM_CH−1 and cont=0: → IDLE, pulse done.
- sample_valid in IDLE or EMIT is dropped.
- start while busy has no effect. The latched cont is not re-sampled mid-scan.
- The SETTLE state is bypassed whenever SETTLE=0.

## Timing
- Reset values: ch_sel=0, result_data=0, result_ch=0, result_valid=0, busy=0, done=0, state=IDLE, acc=0.
- rst has priority over every other input in any state. A rst in the same cycle as start leaves the block in IDLE.
- busy rises the cycle after an accepted start.
- ch_sel updates the cycle after the EMIT handshake; settle counting begins that cycle.
- result_valid rises the cycle after the final accepted ACQ sample. Latency from the last sample to result is 1 cycle.
- Handshake completes on a cycle with result_valid && result_ready. Back-to-back handshakes are impossible, since at least 2^OSR_LOG2 samples separate results.
- done is high for exactly the cycle after the final handshake, coincident with busy=0.
- Full scan with continuous sample_valid: NUM_CH·(SETTLE+2^OSR_LOG2) samples plus one EMIT cycle per channel, with result_ready held high.

## Configuration
- ADC_OS_ROUND_EN defined: result = (acc + 2^(OSR_LOG2−1)) >> OSR_LOG2 (round half up).
  - The sum never exceeds 2^(DATA_W+OSR_LOG2)−1 and the maximum result is 2^DATA_W−1, so no saturation logic is needed.
- ADC_OS_ROUND_EN undefined: plain truncation, acc >> OSR_LOG2.

## Structure
- Package adc_os_pkg holds:
  - the state enum typedef (IDLE/SETTLE/ACQ/EMIT);
  - a clog2-with-minimum-1 function for CH_W;
  - the accumulator-width helper.
- One sub-module, adc_os_accum, contains:
  - acc, the sample counter and the last-sample flag;
  - the truncate/round result stage.
- The top level keeps the FSM, channel counter, settle counter and output registers.

## Test plan
Bench parameters: DATA_W=8, NUM_CH=2, OSR_LOG2=2, SETTLE=1, result_ready=1 unless stated.
- Single scan, cont=0:
  - ch0 samples 99,10,11,12,13 → result_ch=0, result_data=11 (12 with ADC_OS_ROUND_EN).
  - ch1 samples 0,4,4,4,4 → result_data=4, then done pulses once and busy=0.
- Full-scale: 255 on all samples → result_data=255 in both builds; acc reaches 1020 with no wrap.
- Backpressure: result_ready low for 5 cycles with sample_valid toggling → result_valid and result_data stable, samples ignored, ch_sel unchanged until the handshake.
- Continuous wrap: cont=1 → after ch1's result, ch_sel returns to 0 with no done pulse. Start asserted mid-scan has no effect. Dropping cont mid-scan does not stop the loop.
- Reset mid-ACQ: rst after 2 of 4 ch1 samples → all outputs return to reset values next cycle. A new start then yields a fresh ch0 result unaffected by the stale acc.
